// File: rtl/multi_clkdiv.sv
// Multi-channel clock divider: per-channel one-cycle tick enable and 50% square wave,
// with run-time reloadable divisors, global phase realign and divisor readback.

module multiClkdivCh #(
    parameter int               CNT_W   = 26,
    parameter logic [CNT_W-1:0] DEF_DIV = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             syncClr,
    input  logic             wrHit,
    input  logic [CNT_W-1:0] wrDiv,
    output logic             tick,
    output logic             sq,
    output logic [CNT_W-1:0] div
);
    logic [CNT_W-1:0] cnt;
    logic             atTerm;
    logic             divZero;

    // cnt never exceeds div-1, so a plain equality is enough to find the terminal count.
    assign divZero = (div == '0);
    assign atTerm  = (cnt == div - CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div  <= DEF_DIV;
            cnt  <= '0;
            tick <= 1'b0;
            sq   <= 1'b0;
        end else if (syncClr) begin
            cnt  <= '0;
            tick <= 1'b0;
            sq   <= 1'b0;
        end else if (wrHit) begin
            // Restart phase so a stale count can never sit above a smaller new divisor.
            div  <= wrDiv;
            cnt  <= '0;
            tick <= 1'b0;
            sq   <= 1'b0;
        end else if (divZero) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (run) begin
            if (atTerm) begin
                cnt  <= '0;
                tick <= 1'b1;
                sq   <= ~sq;
            end else begin
                cnt  <= cnt + CNT_W'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end
endmodule

module multi_clkdiv #(
    parameter int                      NUM_CH  = 3,
    parameter int                      CNT_W   = 26,
    parameter logic [NUM_CH*CNT_W-1:0] DEF_DIV = {26'd1000000, 26'd50000000, 26'd100000}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic                    sync_clr,
    input  logic                    wr_en,
    input  logic [2:0]              wr_ch,
    input  logic [CNT_W-1:0]        wr_div,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       sq,
    output logic [NUM_CH*CNT_W-1:0] div_q
);
    logic [NUM_CH-1:0]            wrHit;
    logic [NUM_CH-1:0][CNT_W-1:0] divArr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : gCh
            // sync_clr outranks a same-cycle write; out-of-range wr_ch matches no channel.
            assign wrHit[gi] = wr_en && !sync_clr && (wr_ch == 3'(gi));

            multiClkdivCh #(
                .CNT_W  (CNT_W),
                .DEF_DIV(DEF_DIV[gi*CNT_W +: CNT_W])
            ) uCh (
                .clk    (clk),
                .rst    (rst),
                .run    (run),
                .syncClr(sync_clr),
                .wrHit  (wrHit[gi]),
                .wrDiv  (wr_div),
                .tick   (tick[gi]),
                .sq     (sq[gi]),
                .div    (divArr[gi])
            );
        end
    endgenerate

    assign div_q = divArr;
endmodule

// File: tb/tb_multi_clkdiv.sv
// Randomised and directed checks of multi_clkdiv against an edge-count reference model.

module tb_multi_clkdiv;
    localparam int NCH = 3;
    localparam int CW  = 8;
    localparam logic [NCH*CW-1:0] DEFV = {8'd5, 8'd3, 8'd2};

    logic            clk = 1'b0;
    logic            rst;
    logic            run = 1'b0;
    logic            sync_clr = 1'b0;
    logic            wr_en = 1'b0;
    logic [2:0]      wr_ch = '0;
    logic [CW-1:0]   wr_div = '0;
    logic [NCH-1:0]  tick;
    logic [NCH-1:0]  sq;
    logic [NCH*CW-1:0] div_q;

    int checks = 0;
    int errors = 0;

    multi_clkdiv #(.NUM_CH(NCH), .CNT_W(CW), .DEF_DIV(DEFV)) dut (
        .clk(clk), .rst(rst), .run(run), .sync_clr(sync_clr), .wr_en(wr_en),
        .wr_ch(wr_ch), .wr_div(wr_div), .tick(tick), .sq(sq), .div_q(div_q)
    );

    always #5 clk = ~clk;

    // Model: count the edges each channel has actually counted since its last restart.
    // A tick lands on every multiple of div; sq is the parity of completed periods.
    int    mdiv [NCH];
    longint k   [NCH];
    bit    mtick[NCH];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                mdiv[i] = int'(DEFV[i*CW +: CW]); k[i] = 0; mtick[i] = 0;
            end
        end else if (sync_clr) begin
            for (int i = 0; i < NCH; i++) begin k[i] = 0; mtick[i] = 0; end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_en && int'(wr_ch) == i) begin
                    mdiv[i] = int'(wr_div); k[i] = 0; mtick[i] = 0;
                end else if (run && mdiv[i] != 0) begin
                    k[i]++;
                    mtick[i] = (k[i] % mdiv[i]) == 0;
                end else begin
                    mtick[i] = 0;
                end
            end
        end
    end

    function automatic bit expSq(int i);
        if (mdiv[i] == 0) return 1'b0;
        return bit'((k[i] / mdiv[i]) % 2);
    endfunction

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("model_tick%0d", i), longint'(tick[i]), longint'(mtick[i]));
            chk($sformatf("model_sq%0d", i), longint'(sq[i]), longint'(expSq(i)));
            chk($sformatf("model_div%0d", i), longint'(div_q[i*CW +: CW]), longint'(mdiv[i]));
        end
    end

    initial begin
        int tc[NCH];
        int n;
        logic [NCH*CW-1:0] divExp;

        rst = 1'b1;
        run = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_tick", longint'(tick), 0);
        chk("reset_sq", longint'(sq), 0);
        chk("reset_divq", longint'(div_q), longint'(DEFV));

        // Free run from reset: ticks every 2/3/5 edges, first tick2 after edge 5.
        rst = 1'b0;
        for (int i = 0; i < NCH; i++) tc[i] = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) tc[i] += int'(tick[i]);
            if (c == 4) chk("first_tick2_early", longint'(tick[2]), 0);
            if (c == 5) chk("first_tick2", longint'(tick[2]), 1);
        end
        chk("ticks30_ch0", tc[0], 15);
        chk("ticks30_ch1", tc[1], 10);
        chk("ticks30_ch2", tc[2], 6);

        // Reload ch1 while its count sits at 2.
        n = 0;
        while ((k[1] % mdiv[1]) != 2 && n < 10) begin @(negedge clk); n++; end
        chk("wait_cnt1_bound", longint'(n < 10), 1);
        wr_en = 1'b1; wr_ch = 3'd1; wr_div = 8'd4;
        @(negedge clk);
        wr_en = 1'b0;
        chk("wr_divq1", longint'(div_q[CW +: CW]), 4);
        chk("wr_sq1", longint'(sq[1]), 0);
        n = 0;
        do begin @(negedge clk); n++; end while (!tick[1] && n < 10);
        chk("wr_tick1_spacing", n, 4);

        // Pause mid-count.
        run = 1'b0;
        for (int i = 0; i < NCH; i++) tc[i] = 0;
        repeat (7) begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) tc[i] += int'(tick[i]);
        end
        chk("pause_ticks", tc[0] + tc[1] + tc[2], 0);
        run = 1'b1;
        repeat (6) @(negedge clk);

        // sync_clr wins over a simultaneous write.
        sync_clr = 1'b1; wr_en = 1'b1; wr_ch = 3'd2; wr_div = 8'd9;
        @(negedge clk);
        sync_clr = 1'b0; wr_en = 1'b0;
        chk("clr_tick", longint'(tick), 0);
        chk("clr_sq", longint'(sq), 0);
        chk("clr_div2", longint'(div_q[2*CW +: CW]), 5);

        // div 0 silences ch0, div 1 makes it tick every cycle.
        repeat (3) @(negedge clk);
        wr_en = 1'b1; wr_ch = 3'd0; wr_div = 8'd0;
        @(negedge clk);
        wr_en = 1'b0;
        tc[0] = 0;
        repeat (6) begin @(negedge clk); tc[0] += int'(tick[0]); end
        chk("div0_silent", tc[0], 0);
        wr_en = 1'b1; wr_ch = 3'd0; wr_div = 8'd1;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("div1_tick_high", longint'(tick[0]), 1);
        wr_en = 1'b1; wr_ch = 3'd5; wr_div = 8'd7;
        @(negedge clk);
        wr_en = 1'b0;
        divExp = {8'd5, 8'd4, 8'd1};
        chk("oob_write_divq", longint'(div_q), longint'(divExp));

        // Random traffic.
        for (int c = 0; c < 500; c++) begin
            run      = ($urandom_range(0, 7) != 0);
            sync_clr = ($urandom_range(0, 39) == 0);
            wr_en    = ($urandom_range(0, 9) == 0);
            wr_ch    = 3'($urandom_range(0, 7));
            wr_div   = 8'($urandom_range(0, 9));
            @(negedge clk);
        end
        run = 1'b1; sync_clr = 1'b0; wr_en = 1'b0;
        repeat (5) @(negedge clk);

        // Asynchronous reset between edges.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_tick", longint'(tick), 0);
        chk("async_rst_sq", longint'(sq), 0);
        chk("async_rst_divq", longint'(div_q), longint'(DEFV));
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multi_clkdiv.md
Name: multi_clkdiv

Overview:
- Parametrised, multi-channel successor to the fixed three-output game clock divider.
- Generates NUM_CH independent outputs from the single system clock. Each output provides a one-cycle tick enable and a 50%-duty square wave.
- Divisors are reloadable at run time, so game speed and blink rate can change per level.
- Sits at the top level beside the game FSM. Display refresh, LED blink and button sampling consume the ticks as clock enables; the square waves drive LED blinking directly.

Parameters:
NUM_CH, 3, number of divider channels (1..8)
CNT_W, 26, counter/divisor width in bits
DEF_DIV, {26'd1000000, 26'd50000000, 26'd100000}, packed NUM_CH*CNT_W reset divisors; channel 0 in LSBs (ch0 = 100000 fast refresh, ch1 = 50000000 blink, ch2 = 1000000 read)

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  asynchronous active-high reset
run  in  1  1 = channels count; 0 = all counters freeze
sync_clr  in  1  one-cycle pulse; realigns phase of all channels
wr_en  in  1  one-cycle pulse; loads wr_div into channel wr_ch
wr_ch  in  3  target channel index for write
wr_div  in  CNT_W  new divisor value
tick  out  NUM_CH  per-channel one-cycle enable pulse, registered
sq  out  NUM_CH  per-channel square wave, registered
div_q  out  NUM_CH*CNT_W  current divisor registers, for readback

Behaviour:
- Per-channel state:
  - div[i], width CNT_W.
  - cnt[i], width CNT_W.
  - tick[i] and sq[i] flops.
  - All outputs come straight from flops.
- Reset (async, rst=1): div[i]=DEF_DIV slice i, cnt=0, tick=0, sq=0, div_q reflects DEF_DIV. Reset asserted mid-count discards all state immediately.
- Priority on each rising edge, highest first:
  1. sync_clr
  2. wr_en, target channel only
  3. normal counting
- sync_clr=1:
  - Every cnt=0, tick=0, sq=0.
  - div unchanged.
  - A wr_en in the same cycle is ignored.
- wr_en=1 with wr_ch<NUM_CH:
  - div[wr_ch]<=wr_div; cnt[wr_ch]<=0, sq[wr_ch]<=0, tick[wr_ch]<=0.
  - This phase restart guarantees no stale count exceeds a smaller new divisor.
  - Other channels continue normally in the same cycle.
- wr_en=1 with wr_ch>=NUM_CH: ignored; no state changes.
- Counting, when run=1 and div[i]!=0:
  - If cnt[i]==div[i]-1: cnt[i]<=0, tick[i]<=1, sq[i]<=~sq[i].
  - Else: cnt[i]<=cnt[i]+1, tick[i]<=0.
- Resulting timing:
  - tick[i] is high one cycle in every div[i] cycles.
  - sq[i] period = 2*div[i] cycles, 50% duty.
  - The first tick is high during the cycle after the div[i]-th rising edge following reset, clear or write.
- div[i]==1: tick[i] is constantly 1; sq[i] toggles every cycle.
- div[i]==0: channel disabled; cnt held 0, tick 0, sq holds its value.
- run=0:
  - cnt and sq hold; tick forced 0 on the next edge.
  - Resuming continues from the held count, with no lost or extra ticks.
- Arithmetic: unsigned, modulo-free. cnt never exceeds div-1, so no wrap-around is possible. Full-scale divisor 2^CNT_W-1 is supported.
- div_q: concatenation of the div registers, same packing as DEF_DIV. Updates the cycle after a write.

Test Plan (override CNT_W=8, DEF_DIV = ch0 2, ch1 3, ch2 5):
- Release rst with run=1 for 30 cycles -> tick0 every 2nd cycle, tick1 every 3rd, tick2 every 5th; sq periods 4/6/10 cycles; first tick2 rises after the 5th edge.
- Write wr_ch=1, wr_div=4 while cnt1=2 -> sq1 and cnt1 cleared next edge; tick1 spacing becomes 4; ch0 and ch2 undisturbed; div_q slice1 reads 4.
- run=0 for 7 cycles mid-count, then run=1 -> no ticks during pause; the next tick arrives after exactly the remaining count; sq levels held.
- sync_clr and wr_en(ch2, 9) in the same cycle -> all cnt/sq/tick zero; div2 remains 5.
- Write div=0 to ch0, then div=1 -> ch0 silent with sq0 frozen; then tick0 stuck high and sq0 toggling each cycle. Write to wr_ch=5 -> no effect anywhere.
- Assert rst mid-count asynchronously (between edges) -> outputs drop to 0 immediately; div_q returns to 2/3/5.
